serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial two's-complement add/subtract engine for the ALU. It accepts a WIDTH-bit operand pair and an opcode through a valid/ready handshake. It then resolves one bit per clock, LSB first, through a single registered full-adder cell, and returns the sum or difference with carry and signed-overflow flags through a second valid/ready handshake. It sits beside the combinational `add` datapath as the low-area, multi-cycle path, and produces results that are bit-identical to it for addition.

## Interface
- `WIDTH`, default 6: operand and result width in bits; must be ≥ 2.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand pair present.
- `in_ready`  out  1: engine idle and able to accept operands.
- `op`  in  1: 0 = ADD (A+B), 1 = SUB (A−B); sampled with the operands.
- `A`, `B`  in  WIDTH each: two's-complement operands.
- `out_valid`  out  1: the result fields are valid.
- `out_ready`  in  1: consumer accepts the result.
- `RESULT`  out  WIDTH: sum or difference.
- `carry`  out  1: carry out of the MSB (for SUB, 1 = no borrow).
- `overflow`  out  1: signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch A, latch B (inverted when `op`=SUB), set the carry register to `op`, clear the bit counter, and go to SHIFT.
- SHIFT:
  - Each cycle, add bit[cnt] of A and of the latched B with the carry register.
  - Shift the sum bit into the result shift register from the MSB side, update carry, and increment cnt.
  - When cnt reaches WIDTH−1, capture the carry-in of that bit for the overflow calculation, register `carry`/`overflow`, and go to HOLD.
- HOLD:
  - `out_valid`=1 and all outputs are stable.
  - On `out_ready`, go to IDLE.
- Arithmetic:
  - Modulo 2^WIDTH with no sign extension.
  - The opcode and operands are frozen once accepted; `A`, `B` and `op` are ignored outside the IDLE accept cycle.
- `in_valid` while the engine is busy: ignored and not queued. The producer holds `in_valid` until it sees `in_ready`.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `RESULT`=0, `carry`=0, `overflow`=0, cnt=0.
- Reset mid-SHIFT or mid-HOLD: the operation is discarded, no `out_valid` pulse is produced, and the engine returns to IDLE on the first edge after reset deasserts.

## Timing
- Accept edge = T.
- SHIFT occupies edges T+1 … T+WIDTH, one bit per edge.
- `out_valid` rises after edge T+WIDTH. Latency from accept to `out_valid` is WIDTH cycles (6 at the default).
- `out_valid` is held until `out_ready` is sampled high. The return to IDLE happens on that same edge, so `in_ready` is high the next cycle.
- Best-case throughput: one operation per WIDTH+2 cycles (`out_ready` tied high).
- `out_ready` is ignored unless `out_valid`=1.
- `in_ready` and `out_valid` are never high in the same cycle.

## Configuration
- `SERIAL_ADDSUB_SAT_EN` defined:
  - On overflow, RESULT is clamped in HOLD: the positive limit (0 followed by all 1s) when A's sign bit is 0, otherwise the negative limit (1 followed by all 0s).
  - `overflow` still reports 1; `carry` is unchanged.
- Undefined: RESULT wraps modulo 2^WIDTH and no clamp logic is synthesised.

## Structure
- Shared package `alu_pkg` holds:
  - the `alu_op_e` enum (ADD=0, SUB=1);
  - the `addsub_state_e` enum (IDLE, SHIFT, HOLD);
  - the `ALU_WIDTH`=6 default constant.
- One sub-module, `full_adder_cell`: combinational a, b, cin → s, cout, instantiated once. Carry and result storage live in the parent.
- Counter width is $clog2(WIDTH).

## Test plan
- ADD 000001 + 101111 (1 + −17) → RESULT 110000 (−16), overflow 0, carry 0, `out_valid` exactly 6 cycles after accept.
- ADD 011001 + 011001 (25 + 25):
  - without the macro → RESULT 110010, overflow 1;
  - with `SERIAL_ADDSUB_SAT_EN` → RESULT 011111, overflow 1.
- ADD 101101 + 101111 (−19 + −17):
  - without the macro → RESULT 011100, overflow 1, carry 1;
  - with the macro → RESULT 100000.
- SUB 000000 − 100000 (0 − (−32)) → RESULT 100000, overflow 1. SUB 000101 − 000011 → RESULT 000010, overflow 0, carry 1.
- Back-pressure: hold `out_ready`=0 for 5 cycles and change A, B and `in_valid` meanwhile → RESULT stable, `in_ready`=0 throughout, no new operation accepted.
- Assert `reset` at SHIFT bit 3 → all outputs at reset values immediately, no `out_valid` afterwards; next operation 000010 + 000011 → RESULT 000101.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU types: opcode enum, add/sub engine states, widths.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } addsub_state_e;

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_cell
// Brief    : Single-bit combinational full adder used by the serial engine.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub
// Brief    : Bit-serial two's-complement add/subtract, LSB first, one bit per
//            clock. Define SERIAL_ADDSUB_SAT_EN to clamp RESULT on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RESULT,
    output logic             carry,
    output logic             overflow
);

    localparam int             c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    addsub_state_e      r_state;
    addsub_state_e      w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_cy;
    logic               r_carry;
    logic               r_ovf;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_result;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serial datapath: one full-adder cell, carry held between cycles
    // ------------------------------------------------------------------
    full_adder_cell u_fa (
        .a    (r_a[r_cnt]),
        .b    (r_b[r_cnt]),
        .cin  (r_cy),
        .s    (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here, seed the carry with op.
            r_a   <= A;
            r_b   <= (alu_op_e'(op) == SUB) ? ~B : B;
            r_cy  <= op;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_res <= {w_sum, r_res[WIDTH-1:1]};
            r_cy  <= w_cout;
            if (w_last) begin
                r_cnt   <= '0;
                r_carry <= w_cout;
                r_ovf   <= r_cy ^ w_cout;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

`ifdef SERIAL_ADDSUB_SAT_EN
    // Clamp toward the sign of A; overflow only occurs when the true result
    // shares A's sign, so A's MSB picks the correct limit for ADD and SUB.
    always_comb begin
        w_result = r_res;
        if ((r_state == HOLD) && r_ovf) begin
            w_result = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_result = r_res;
`endif

    assign RESULT   = w_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub
// Brief    : Scoreboard-based self-checking bench for serial_addsub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;
    import alu_pkg::*;

    localparam int W = 6;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] RESULT;
    logic         carry;
    logic         overflow;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RESULT    (RESULT),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        logic [W:0] s;
        int         sa;
        int         sb;
        int         t;
        exp_t       e;
        s     = {1'b0, a} + {1'b0, (o ? ~b : b)} + (W+1)'(o);
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        t     = o ? (sa - sb) : (sa + sb);
        e.v   = (t > 31) || (t < -32);
        e.c   = s[W];
        e.res = s[W-1:0];
`ifdef SERIAL_ADDSUB_SAT_EN
        if (e.v) e.res = a[W-1] ? 6'b100000 : 6'b011111;
`endif
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o, output int acc);
        int n;
        n        = 0;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        op       = o;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock);
        acc = int'($time / 10);
        #1;
        in_valid = 1'b0;
        A        = 6'($urandom);
        B        = 6'($urandom);
        op       = 1'($urandom);
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clock); #1;
            k++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (RESULT !== 6'b0) begin errors++; $display("FAIL reset_result: got %b expected 000000", RESULT); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         to [5];
        exp_t         te [5];
        exp_t         e;
        int           acc;
        int           k;
        ta = '{6'b000001, 6'b011001, 6'b101101, 6'b000000, 6'b000101};
        tb = '{6'b101111, 6'b011001, 6'b101111, 6'b100000, 6'b000011};
        to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SERIAL_ADDSUB_SAT_EN
        te = '{{6'b110000, 1'b0, 1'b0}, {6'b011111, 1'b0, 1'b1}, {6'b100000, 1'b1, 1'b1},
               {6'b011111, 1'b0, 1'b1}, {6'b000010, 1'b1, 1'b0}};
`else
        te = '{{6'b110000, 1'b0, 1'b0}, {6'b110010, 1'b0, 1'b1}, {6'b011100, 1'b1, 1'b1},
               {6'b100000, 1'b0, 1'b1}, {6'b000010, 1'b1, 1'b0}};
`endif
        for (int i = 0; i < 5; i++) begin
            q.push_back(te[i]);
            send(ta[i], tb[i], to[i], acc);
            wait_out(k);
            e = q.pop_front();
            checks++; if (k !== W) begin errors++; $display("FAIL arith%0d_latency: got %0d expected %0d", i, k, W); end
            checks++; if (RESULT !== e.res) begin errors++; $display("FAIL arith%0d_result: got %b expected %b", i, RESULT, e.res); end
            checks++; if (carry !== e.c) begin errors++; $display("FAIL arith%0d_carry: got %b expected %b", i, carry, e.c); end
            checks++; if (overflow !== e.v) begin errors++; $display("FAIL arith%0d_overflow: got %b expected %b", i, overflow, e.v); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arith%0d_ready_in_hold: got %b expected 0", i, in_ready); end
            consume();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL arith%0d_release: got in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   acc;
        int   k;
        int   seen;
        q.push_back('{6'b000010, 1'b1, 1'b0});
        send(6'b000101, 6'b000011, 1'b1, acc);
        wait_out(k);
        e = q.pop_front();
        checks++; if (k !== W) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", k, W); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            A        = 6'($urandom);
            B        = 6'($urandom);
            op       = 1'($urandom);
            @(posedge clock); #1;
            checks++; if (RESULT !== e.res || carry !== e.c || overflow !== e.v) begin
                errors++; $display("FAIL bp_stable%0d: got %b/%b/%b expected %b/%b/%b", i, RESULT, carry, overflow, e.res, e.c, e.v);
            end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_handshake%0d: got in_ready=%b out_valid=%b expected 0/1", i, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        consume();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || !in_ready) seen++;
            @(posedge clock); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL bp_no_new_op: got %0d busy cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        int   acc;
        int   k;
        int   seen;
        send(6'b011001, 6'b011001, 1'b0, acc);
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_handshake: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++; if (RESULT !== 6'b0 || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b/%b/%b expected 000000/0/0", RESULT, carry, overflow);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d valid cycles expected 0", seen); end
        q.push_back('{6'b000101, 1'b0, 1'b0});
        send(6'b000010, 6'b000011, 1'b0, acc);
        wait_out(k);
        e = q.pop_front();
        checks++; if (k !== W) begin errors++; $display("FAIL rst_next_latency: got %0d expected %0d", k, W); end
        checks++; if (RESULT !== e.res || carry !== e.c || overflow !== e.v) begin
            errors++; $display("FAIL rst_next_result: got %b/%b/%b expected %b/%b/%b", RESULT, carry, overflow, e.res, e.c, e.v);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         o;
        int           acc;
        int           prev;
        int           k;
        out_ready = 1'b1;
        prev      = 0;
        for (int i = 0; i < 12; i++) begin
            a = 6'($urandom);
            b = 6'($urandom);
            o = 1'($urandom);
            q.push_back(model(a, b, o));
            send(a, b, o, acc);
            if (i > 0) begin
                checks++; if (acc - prev !== W + 2) begin errors++; $display("FAIL b2b_interval%0d: got %0d expected %0d", i, acc - prev, W + 2); end
            end
            prev = acc;
            wait_out(k);
            e = q.pop_front();
            checks++; if (RESULT !== e.res || carry !== e.c || overflow !== e.v) begin
                errors++; $display("FAIL b2b_result%0d: %b %s %b got %b/%b/%b expected %b/%b/%b",
                                   i, a, o ? "-" : "+", b, RESULT, carry, overflow, e.res, e.c, e.v);
            end
        end
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
